// File: rtl/alu_4bit.sv
// alu_4bit: one-operation-per-cycle ALU with registered result and C/Z/N/V flags.
// Every output is a flop; inputs are sampled on each rising clk edge and the
// result appears after that edge.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate (unsigned) instead of wrapping.
module alu_4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,    // synchronous, active-high despite the name
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic [WIDTH-1:0] RESULT,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic             N_FLAG,
    output logic             V_FLAG
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;
    localparam logic [2:0] OpShr = 3'b111;

    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH-1:0] result_d, result_q;
    logic             c_d, c_q;
    logic             z_d, z_q;
    logic             n_d, n_q;
    logic             v_d, v_q;

    // Extra top bit holds the carry (ADD) or borrow (SUB).
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;

    // Decode the opcode into the next result and flags; every opcode is covered.
    always_comb begin
        sum      = {1'b0, OP1} + {1'b0, OP2};
        diff     = {1'b0, OP1} - {1'b0, OP2};
        result_d = '0;
        c_d      = 1'b0;
        v_d      = 1'b0;
        unique case (OPCODE)
            OpAdd: begin
                result_d = sum[WIDTH-1:0];
                c_d      = sum[WIDTH];
                v_d      = (OP1[Msb] == OP2[Msb]) && (sum[Msb] != OP1[Msb]);
`ifdef ALU_SAT_EN
                if (sum[WIDTH]) result_d = '1;
`endif
            end
            OpSub: begin
                result_d = diff[WIDTH-1:0];
                c_d      = diff[WIDTH];
                // V reflects the unsaturated difference in both builds.
                v_d      = (OP1[Msb] != OP2[Msb]) && (diff[Msb] != OP1[Msb]);
`ifdef ALU_SAT_EN
                if (diff[WIDTH]) result_d = '0;
`endif
            end
            OpAnd: result_d = OP1 & OP2;
            OpOr:  result_d = OP1 | OP2;
            OpXor: result_d = OP1 ^ OP2;
            OpNot: result_d = ~OP1;
            OpShl: begin
                result_d = {OP1[WIDTH-2:0], 1'b0};
                c_d      = OP1[Msb];
                v_d      = OP1[Msb] ^ OP1[Msb-1];
            end
            OpShr: begin
                result_d = {1'b0, OP1[WIDTH-1:1]};
                c_d      = OP1[0];
            end
            default: ;
        endcase
        z_d = (result_d == '0);
        n_d = result_d[Msb];
    end

    // Register result and flags; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rstn) begin
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b1;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
        end
    end

    assign RESULT = result_q;
    assign C_FLAG = c_q;
    assign Z_FLAG = z_q;
    assign N_FLAG = n_q;
    assign V_FLAG = v_q;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed bench for alu_4bit; expected vectors are packed {RESULT, C, Z, N, V}.
module tb_alu_4bit;

    logic       clk;
    logic       rstn;
    logic [2:0] OPCODE;
    logic [3:0] OP1;
    logic [3:0] OP2;
    logic [3:0] RESULT;
    logic       C_FLAG;
    logic       Z_FLAG;
    logic       N_FLAG;
    logic       V_FLAG;

    int n_pass  = 0;
    int n_total = 0;

    alu_4bit #(.WIDTH(4)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .OPCODE (OPCODE),
        .OP1    (OP1),
        .OP2    (OP2),
        .RESULT (RESULT),
        .C_FLAG (C_FLAG),
        .Z_FLAG (Z_FLAG),
        .N_FLAG (N_FLAG),
        .V_FLAG (V_FLAG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {RESULT, C_FLAG, Z_FLAG, N_FLAG, V_FLAG};
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed {R,C,Z,N,V}=%h_%b%b%b%b expected %h_%b%b%b%b", tag,
                    obs[7:4], obs[3], obs[2], obs[1], obs[0],
                    exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic step(input string tag, input logic rst, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
        @(negedge clk);
        rstn   = rst;
        OPCODE = op;
        OP1    = a;
        OP2    = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        rstn   = 1'b1;
        OPCODE = 3'b000;
        OP1    = 4'h0;
        OP2    = 4'h0;

        // Reset
        step("reset0",     1'b1, 3'b000, 4'h0, 4'h0, {4'h0, 4'b0100});
        step("reset1",     1'b1, 3'b000, 4'h0, 4'h0, {4'h0, 4'b0100});
        step("reset_wins", 1'b1, 3'b000, 4'h5, 4'h3, {4'h0, 4'b0100});

        // ADD
        step("add_7_1", 1'b0, 3'b000, 4'h7, 4'h1, {4'h8, 4'b0011});
`ifdef ALU_SAT_EN
        step("add_f_1", 1'b0, 3'b000, 4'hF, 4'h1, {4'hF, 4'b1010});
`else
        step("add_f_1", 1'b0, 3'b000, 4'hF, 4'h1, {4'h0, 4'b1100});
`endif

        // SUB
`ifdef ALU_SAT_EN
        step("sub_3_5", 1'b0, 3'b001, 4'h3, 4'h5, {4'h0, 4'b1100});
`else
        step("sub_3_5", 1'b0, 3'b001, 4'h3, 4'h5, {4'hE, 4'b1010});
`endif
        step("sub_8_1", 1'b0, 3'b001, 4'h8, 4'h1, {4'h7, 4'b0001});

        // Logic ops
        step("and_c_a", 1'b0, 3'b010, 4'hC, 4'hA, {4'h8, 4'b0010});
        step("or_c_3",  1'b0, 3'b011, 4'hC, 4'h3, {4'hF, 4'b0010});
        step("xor_a_a", 1'b0, 3'b100, 4'hA, 4'hA, {4'h0, 4'b0100});
        step("not_5",   1'b0, 3'b101, 4'h5, 4'hF, {4'hA, 4'b0010});

        // Shifts
        step("shl_9", 1'b0, 3'b110, 4'h9, 4'h0, {4'h2, 4'b1001});
        step("shr_9", 1'b0, 3'b111, 4'h9, 4'h0, {4'h4, 4'b1000});

        // Back-to-back, one result per cycle
        step("b2b_add_1_1", 1'b0, 3'b000, 4'h1, 4'h1, {4'h2, 4'b0000});
        step("b2b_sub_4_4", 1'b0, 3'b001, 4'h4, 4'h4, {4'h0, 4'b0100});
        step("b2b_shl_1",   1'b0, 3'b110, 4'h1, 4'h0, {4'h2, 4'b0000});

        // No combinational path: new inputs must not show before the edge
        @(negedge clk);
        OPCODE = 3'b011;
        OP1    = 4'h8;
        OP2    = 4'h1;
        #2;
        check("no_comb_path", {4'h2, 4'b0000});
        @(posedge clk);
        #1;
        check("or_8_1", {4'h9, 4'b0010});

        // Mid-stream reset discards the in-flight op
        step("midstream_reset", 1'b1, 3'b000, 4'h7, 4'h1, {4'h0, 4'b0100});
        step("after_reset",     1'b0, 3'b001, 4'h0, 4'h1, {4'hF, 4'b1010} `ifdef ALU_SAT_EN
             & 8'h00 | {4'h0, 4'b1100} `endif);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected summary");
        $fatal(1);
    end

endmodule
